// File: rtl/memoria_cache_if.sv
// CPU <-> cache request/status bundle for memoria_cache.
// hit_count only exists when HIT_COUNT_EN is defined.
interface memoria_cache_if #(
    parameter int unsigned DATA_W  = 3,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned INDEX_W = 2
);
    logic                      wren;
    logic [DATA_W-1:0]         data;
    logic [ADDR_W-1:0]         address;
    logic                      hit;
    logic                      valid;
    logic                      LRU;
    logic                      dirty;
    logic                      writeBack;
    logic [ADDR_W-INDEX_W-1:0] tag;
    logic [DATA_W-1:0]         dadoParaCPU;
`ifdef HIT_COUNT_EN
    logic [7:0]                hit_count;
`endif

    modport master (
        output wren, data, address,
        input  hit, valid, LRU, dirty, writeBack, tag, dadoParaCPU
`ifdef HIT_COUNT_EN
        , input hit_count
`endif
    );

    modport slave (
        input  wren, data, address,
        output hit, valid, LRU, dirty, writeBack, tag, dadoParaCPU
`ifdef HIT_COUNT_EN
        , output hit_count
`endif
    );
endinterface

// File: rtl/memoria_cache.sv
// 2-way set-associative write-back/write-allocate cache over a 32x3 internal memory.
// Optional HIT_COUNT_EN adds an 8-bit wrapping LOOKUP-hit counter.
module memoria_cache #(
    parameter int unsigned DATA_W  = 3,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned INDEX_W = 2
) (
    input logic             clock,
    input logic             reset,
    memoria_cache_if.slave  bus
);
    localparam int unsigned TagW  = ADDR_W - INDEX_W;
    localparam int unsigned Sets  = 1 << INDEX_W;
    localparam int unsigned Words = 1 << ADDR_W;

    typedef enum logic [1:0] {StLookup, StWriteback, StAllocate} state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] line_data_q  [Sets][2];
    logic [TagW-1:0]   line_tag_q   [Sets][2];
    logic [1:0]        line_valid_q [Sets];
    logic [1:0]        line_dirty_q [Sets];
    logic [Sets-1:0]   lru_q;
    logic [DATA_W-1:0] mem_q        [Words];

    // Miss context survives WRITEBACK/ALLOCATE even if the CPU changes its request.
    logic [ADDR_W-1:0] req_addr_q;
    logic              victim_q;

    logic              hit_q, valid_q, lru_out_q, dirty_q, writeback_q;
    logic [TagW-1:0]   tag_q;
    logic [DATA_W-1:0] dout_q;

    logic [INDEX_W-1:0] index, a_idx;
    logic [TagW-1:0]    req_tag;
    logic [1:0]         match;
    logic               lookup_hit, hit_way, victim_way;

    assign index   = bus.address[INDEX_W-1:0];
    assign req_tag = bus.address[ADDR_W-1:INDEX_W];
    assign a_idx   = req_addr_q[INDEX_W-1:0];

    always_comb begin
        for (int w = 0; w < 2; w++) begin
            match[w] = line_valid_q[index][w] && (line_tag_q[index][w] == req_tag);
        end
        lookup_hit = |match;
        hit_way    = match[1];
        if (!line_valid_q[index][0])      victim_way = 1'b0;
        else if (!line_valid_q[index][1]) victim_way = 1'b1;
        else                              victim_way = lru_q[index];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLookup: begin
                if (!lookup_hit) begin
                    state_d = (line_valid_q[index][victim_way] && line_dirty_q[index][victim_way])
                              ? StWriteback : StAllocate;
                end
            end
            StWriteback: state_d = StAllocate;
            StAllocate:  state_d = StLookup;
            default:     state_d = StLookup;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= StLookup;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < Sets; s++) begin
                line_valid_q[s] <= '0;
                line_dirty_q[s] <= '0;
                for (int w = 0; w < 2; w++) begin
                    line_data_q[s][w] <= '0;
                    line_tag_q[s][w]  <= '0;
                end
            end
            for (int i = 0; i < Words; i++) mem_q[i] <= DATA_W'(i);
            lru_q       <= '0;
            req_addr_q  <= '0;
            victim_q    <= 1'b0;
            hit_q       <= 1'b0;
            valid_q     <= 1'b0;
            lru_out_q   <= 1'b0;
            dirty_q     <= 1'b0;
            writeback_q <= 1'b0;
            tag_q       <= '0;
            dout_q      <= '0;
        end else begin
            writeback_q <= 1'b0;
            unique case (state_q)
                StLookup: begin
                    if (lookup_hit) begin
                        hit_q         <= 1'b1;
                        lru_q[index]  <= ~hit_way;
                        lru_out_q     <= ~hit_way;
                        valid_q       <= 1'b1;
                        tag_q         <= req_tag;
                        if (bus.wren) begin
                            line_data_q[index][hit_way]  <= bus.data;
                            line_dirty_q[index][hit_way] <= 1'b1;
                            dout_q                       <= bus.data;
                            dirty_q                      <= 1'b1;
                        end else begin
                            dout_q  <= line_data_q[index][hit_way];
                            dirty_q <= line_dirty_q[index][hit_way];
                        end
                    end else begin
                        hit_q      <= 1'b0;
                        req_addr_q <= bus.address;
                        victim_q   <= victim_way;
                    end
                end
                StWriteback: begin
                    mem_q[{line_tag_q[a_idx][victim_q], a_idx}] <= line_data_q[a_idx][victim_q];
                    writeback_q <= 1'b1;
                end
                StAllocate: begin
                    line_data_q[a_idx][victim_q]  <= mem_q[req_addr_q];
                    line_tag_q[a_idx][victim_q]   <= req_addr_q[ADDR_W-1:INDEX_W];
                    line_valid_q[a_idx][victim_q] <= 1'b1;
                    line_dirty_q[a_idx][victim_q] <= 1'b0;
                    valid_q <= 1'b1;
                    dirty_q <= 1'b0;
                    tag_q   <= req_addr_q[ADDR_W-1:INDEX_W];
                end
                default: ;
            endcase
        end
    end

`ifdef HIT_COUNT_EN
    logic [7:0] hit_count_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                                hit_count_q <= '0;
        else if (state_q == StLookup && lookup_hit) hit_count_q <= hit_count_q + 8'd1;
    end
    assign bus.hit_count = hit_count_q;
`endif

    assign bus.hit         = hit_q;
    assign bus.valid       = valid_q;
    assign bus.LRU         = lru_out_q;
    assign bus.dirty       = dirty_q;
    assign bus.writeBack   = writeback_q;
    assign bus.tag         = tag_q;
    assign bus.dadoParaCPU = dout_q;
endmodule

// File: tb/tb_memoria_cache.sv
// Self-checking bench for memoria_cache: cache/memory model plus per-cycle output compare.
module tb_memoria_cache;
    logic clock = 1'b0;
    logic reset;
    memoria_cache_if bus ();

    memoria_cache dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Abstract model: sets of two lines plus flat memory.
    logic [2:0] m_mem  [32];
    logic [2:0] m_data [4][2];
    logic [2:0] m_tag  [4][2];
    logic       m_valid[4][2];
    logic       m_dirty[4][2];
    logic       m_lru  [4];
    int         m_hits;

    logic       chk_en = 1'b0;
    logic       exp_hit, exp_wb, exp_full;
    logic [2:0] exp_dout, exp_tag;
    logic       exp_valid, exp_dirty, exp_lru;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            logic [4:0] iv;
            iv = 5'(i);
            m_mem[i] = iv[2:0];
        end
        for (int s = 0; s < 4; s++) begin
            m_lru[s] = 1'b0;
            for (int w = 0; w < 2; w++) begin
                m_data[s][w] = '0; m_tag[s][w] = '0;
                m_valid[s][w] = 1'b0; m_dirty[s][w] = 1'b0;
            end
        end
        m_hits = 0;
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("hit", bus.hit, exp_hit);
            chk("writeBack", bus.writeBack, exp_wb);
            if (exp_full) begin
                chk("dadoParaCPU", bus.dadoParaCPU, exp_dout);
                chk("valid", bus.valid, exp_valid);
                chk("dirty", bus.dirty, exp_dirty);
                chk("tag", bus.tag, exp_tag);
                chk("LRU", bus.LRU, exp_lru);
`ifdef HIT_COUNT_EN
                chk("hit_count", bus.hit_count, m_hits);
`endif
            end
        end
    end

    // One CPU request, held until the model says it completes.
    task automatic do_access(input logic w, input logic [2:0] d, input logic [4:0] a,
                             output logic [2:0] rd);
        logic [1:0] s;
        logic [2:0] tg;
        logic       way, found, wb;
        int         lat;
        s = a[1:0];
        tg = a[4:2];
        found = 1'b0; way = 1'b0; wb = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (m_valid[s][k] && m_tag[s][k] == tg) begin
                found = 1'b1; way = 1'(k);
            end
        end
        if (found) begin
            lat = 1;
        end else begin
            if (!m_valid[s][0])      way = 1'b0;
            else if (!m_valid[s][1]) way = 1'b1;
            else                     way = m_lru[s];
            wb = m_valid[s][way] && m_dirty[s][way];
            lat = wb ? 4 : 3;
            if (wb) m_mem[{m_tag[s][way], s}] = m_data[s][way];
            m_data[s][way] = m_mem[a];
            m_tag[s][way] = tg;
            m_valid[s][way] = 1'b1;
            m_dirty[s][way] = 1'b0;
        end
        if (w) begin
            m_data[s][way] = d;
            m_dirty[s][way] = 1'b1;
        end
        m_lru[s] = ~way;
        m_hits = (m_hits + 1) % 256;
        exp_dout = m_data[s][way]; exp_valid = 1'b1; exp_dirty = m_dirty[s][way];
        exp_tag = tg; exp_lru = m_lru[s];

        bus.wren = w; bus.data = d; bus.address = a;
        for (int n = 1; n <= lat; n++) begin
            @(posedge clock);
            #1;
            exp_hit = (n == lat);
            exp_full = (n == lat);
            exp_wb = wb && (n == 2);
            chk_en = 1'b1;
            @(negedge clock);
            #1;
        end
        chk_en = 1'b0;
        rd = bus.dadoParaCPU;
    endtask

    logic [2:0] rd;

    initial begin
        bus.wren = 1'b0; bus.data = '0; bus.address = '0;
        reset = 1'b1;
        model_reset();
        #12;
        chk("reset hit", bus.hit, 0);
        chk("reset dout", bus.dadoParaCPU, 0);
        chk("reset valid", bus.valid, 0);
        chk("reset tag", bus.tag, 0);
        @(negedge clock);
        reset = 1'b0;

        do_access(1'b0, 3'd0, 5'b00001, rd); chk("lit rd 00001", rd, 1);
        do_access(1'b1, 3'd5, 5'b00001, rd); chk("lit wr 5", rd, 5);
        do_access(1'b1, 3'd4, 5'b01001, rd); chk("lit wr 4 LRU", bus.LRU, 0);
        do_access(1'b0, 3'd0, 5'b00101, rd); chk("lit rd 00101", rd, 5);
        do_access(1'b1, 3'd1, 5'b01101, rd);
        do_access(1'b0, 3'd0, 5'b00001, rd); chk("lit rd 00001 again", rd, 5);
        do_access(1'b0, 3'd0, 5'b01001, rd); chk("lit rd 01001", rd, 4);
        do_access(1'b1, 3'd7, 5'b00001, rd);
        do_access(1'b0, 3'd0, 5'b01001, rd);
        do_access(1'b0, 3'd0, 5'b10010, rd); chk("lit rd 10010", rd, 2);

        // Dirty miss on set 1, then reset while in WRITEBACK.
        bus.wren = 1'b0; bus.address = 5'b10001;
        @(posedge clock);
        #1;
        chk("pre-reset hit", bus.hit, 0);
        reset = 1'b1;
        #1;
        chk("mid reset hit", bus.hit, 0);
        chk("mid reset valid", bus.valid, 0);
        chk("mid reset LRU", bus.LRU, 0);
        chk("mid reset dirty", bus.dirty, 0);
        chk("mid reset writeBack", bus.writeBack, 0);
        chk("mid reset tag", bus.tag, 0);
        chk("mid reset dout", bus.dadoParaCPU, 0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        do_access(1'b0, 3'd0, 5'b00001, rd); chk("lit post-reset rd", rd, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
